// File: rtl/iob_pfsm_dwell.sv
// Programmable FSM with per-transition dwell, run/halt/step control and a
// state breakpoint. The LUT is indexed by {state, inputs} and each word holds
// {dwell, next_state, outputs}.
module iob_pfsm_dwell #(
  parameter int unsigned STATE_W  = 2,
  parameter int unsigned INPUT_W  = 2,
  parameter int unsigned OUTPUT_W = 4,
  parameter int unsigned DWELL_W  = 8,
  parameter int unsigned ENTRY_W  = DWELL_W + STATE_W + OUTPUT_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cke_i,
  input  logic                       lut_we_i,
  input  logic [STATE_W+INPUT_W-1:0] lut_addr_i,
  input  logic [ENTRY_W-1:0]         lut_wdata_i,
  input  logic                       run_i,
  input  logic                       halt_i,
  input  logic                       step_i,
  input  logic                       stop_i,
  input  logic                       bkpt_en_i,
  input  logic [STATE_W-1:0]         bkpt_state_i,
  input  logic [INPUT_W-1:0]         input_ports_i,
  output logic [OUTPUT_W-1:0]        output_ports_o,
  output logic [STATE_W-1:0]         state_o,
  output logic [1:0]                 mode_o,
  output logic                       bkpt_hit_o
);

  localparam int unsigned AddrW = STATE_W + INPUT_W;
  localparam int unsigned Depth = 2 ** AddrW;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StWait = 2'd2,
    StHalt = 2'd3
  } mode_e;

  logic [ENTRY_W-1:0]  lut_q [Depth];
  mode_e               mode_q, mode_d;
  logic [STATE_W-1:0]  state_q, state_d;
  logic [OUTPUT_W-1:0] out_q, out_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [STATE_W-1:0]  pend_q, pend_d;
  logic                hit_q, hit_d;
  // stepping: the current WAIT was started by step_i and returns to HALT.
  logic                stepping_q, stepping_d;
  // paused: HALT was entered from WAIT, so run_i resumes the dwell.
  logic                paused_q, paused_d;
  logic                do_eval;

  logic [AddrW-1:0]    rd_addr;
  logic [ENTRY_W-1:0]  entry;
  logic [OUTPUT_W-1:0] e_out;
  logic [STATE_W-1:0]  e_next;
  logic [DWELL_W-1:0]  e_dwell;

  assign rd_addr = {state_q, input_ports_i};
  assign entry   = lut_q[rd_addr];
  assign e_out   = entry[OUTPUT_W-1:0];
  assign e_next  = entry[OUTPUT_W +: STATE_W];
  assign e_dwell = entry[OUTPUT_W+STATE_W +: DWELL_W];

  // LUT write port; read is asynchronous so a same-cycle write sees old data.
  always_ff @(posedge clk_i) begin
    if (cke_i && lut_we_i) begin
      lut_q[lut_addr_i] <= lut_wdata_i;
    end
  end

  // Control-mode next-state and PFSM datapath update.
  always_comb begin
    mode_d     = mode_q;
    state_d    = state_q;
    out_d      = out_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    hit_d      = 1'b0;
    stepping_d = stepping_q;
    paused_d   = paused_q;
    do_eval    = 1'b0;

    if (stop_i) begin
      mode_d     = StIdle;
      state_d    = '0;
      cnt_d      = '0;
      stepping_d = 1'b0;
      paused_d   = 1'b0;
    end else begin
      unique case (mode_q)
        StIdle: begin
          if (run_i) mode_d = StRun;
        end
        StRun: begin
          if (halt_i) mode_d = StHalt;
          else        do_eval = 1'b1;
        end
        StWait: begin
          if (halt_i) begin
            mode_d   = StHalt;
            paused_d = 1'b1;
          end else if (cnt_q == DWELL_W'(1)) begin
            state_d    = pend_q;
            cnt_d      = '0;
            stepping_d = 1'b0;
            if (bkpt_en_i && (pend_q == bkpt_state_i)) begin
              mode_d = StHalt;
              hit_d  = 1'b1;
            end else if (stepping_q) begin
              mode_d = StHalt;
            end else begin
              mode_d = StRun;
            end
          end else begin
            cnt_d = cnt_q - DWELL_W'(1);
          end
        end
        StHalt: begin
          if (run_i) begin
            mode_d     = paused_q ? StWait : StRun;
            paused_d   = 1'b0;
            stepping_d = 1'b0;
          end else if (step_i) begin
            if (paused_q) begin
              mode_d     = StWait;
              paused_d   = 1'b0;
              stepping_d = 1'b1;
            end else begin
              do_eval = 1'b1;
            end
          end
        end
      endcase

      // One RUN-cycle evaluation, shared by RUN and single-step from HALT.
      if (do_eval) begin
        out_d = e_out;
        if (e_dwell == '0) begin
          state_d = e_next;
          if (mode_q == StRun && bkpt_en_i && (e_next == bkpt_state_i)) begin
            mode_d = StHalt;
            hit_d  = 1'b1;
          end
        end else begin
          cnt_d      = e_dwell;
          pend_d     = e_next;
          mode_d     = StWait;
          stepping_d = (mode_q == StHalt);
        end
      end
    end
  end

  // State registers; cke_i low freezes everything.
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        mode_q     <= StIdle;
        state_q    <= '0;
        out_q      <= '0;
        cnt_q      <= '0;
        pend_q     <= '0;
        hit_q      <= 1'b0;
        stepping_q <= 1'b0;
        paused_q   <= 1'b0;
      end else begin
        mode_q     <= mode_d;
        state_q    <= state_d;
        out_q      <= out_d;
        cnt_q      <= cnt_d;
        pend_q     <= pend_d;
        hit_q      <= hit_d;
        stepping_q <= stepping_d;
        paused_q   <= paused_d;
      end
    end
  end

  assign output_ports_o = out_q;
  assign state_o        = state_q;
  assign mode_o         = mode_q;
  assign bkpt_hit_o     = hit_q;

endmodule

// File: tb/tb_iob_pfsm_dwell.sv
// Scoreboard bench for iob_pfsm_dwell: stimulus pushes the expected
// post-edge view, a negedge monitor pops and compares.
module tb_iob_pfsm_dwell;

  localparam logic [1:0] MI = 2'd0;
  localparam logic [1:0] MR = 2'd1;
  localparam logic [1:0] MW = 2'd2;
  localparam logic [1:0] MH = 2'd3;

  logic        clk = 1'b0;
  logic        rst, cke, lut_we, run, halt, step, stop, bkpt_en;
  logic [3:0]  lut_addr;
  logic [13:0] lut_wdata;
  logic [1:0]  bkpt_state, in_ports;
  logic [3:0]  out_ports;
  logic [1:0]  state, mode;
  logic        bkpt_hit;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      nm;
    logic [1:0] st;
    logic [1:0] md;
    logic [3:0] op;
    logic       hit;
  } exp_t;

  exp_t q[$];

  iob_pfsm_dwell dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cke_i          (cke),
    .lut_we_i       (lut_we),
    .lut_addr_i     (lut_addr),
    .lut_wdata_i    (lut_wdata),
    .run_i          (run),
    .halt_i         (halt),
    .step_i         (step),
    .stop_i         (stop),
    .bkpt_en_i      (bkpt_en),
    .bkpt_state_i   (bkpt_state),
    .input_ports_i  (in_ports),
    .output_ports_o (out_ports),
    .state_o        (state),
    .mode_o         (mode),
    .bkpt_hit_o     (bkpt_hit)
  );

  always #5 clk = ~clk;

  // Monitor: compare the DUT view against the oldest queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (state !== e.st || mode !== e.md || out_ports !== e.op || bkpt_hit !== e.hit) begin
        bad++;
        $display("FAIL %s: got st=%0d md=%0d out=%h hit=%0b, want st=%0d md=%0d out=%h hit=%0b",
                 e.nm, state, mode, out_ports, bkpt_hit, e.st, e.md, e.op, e.hit);
      end
    end
  end

  task automatic idle_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input string nm, input logic [1:0] st, input logic [1:0] md,
                      input logic [3:0] op, input logic hit);
    exp_t e;
    @(posedge clk);
    #1;
    e.nm  = nm;
    e.st  = st;
    e.md  = md;
    e.op  = op;
    e.hit = hit;
    q.push_back(e);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [7:0] dw, input logic [1:0] nx,
                    input logic [3:0] op);
    lut_we    = 1'b1;
    lut_addr  = addr;
    lut_wdata = {dw, nx, op};
    idle_cyc();
    lut_we    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cke = 1'b1; lut_we = 1'b0; lut_addr = '0; lut_wdata = '0;
    run = 1'b0; halt = 1'b0; step = 1'b0; stop = 1'b0;
    bkpt_en = 1'b0; bkpt_state = '0; in_ports = '0;

    idle_cyc();
    tick("reset", 2'd0, MI, 4'h0, 1'b0);
    rst = 1'b0;

    // 4-state ring, dwell 0, outputs one-hot of the source state.
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 4; i++) begin
        wr(4'(s * 4 + i), 8'd0, 2'(s + 1), 4'(1 << s));
      end
    end

    run = 1'b1; tick("ring_run", 2'd0, MR, 4'h0, 1'b0); run = 1'b0;
    tick("ring_s1", 2'd1, MR, 4'h1, 1'b0);
    tick("ring_s2", 2'd2, MR, 4'h2, 1'b0);
    tick("ring_s3", 2'd3, MR, 4'h4, 1'b0);
    tick("ring_s0", 2'd0, MR, 4'h8, 1'b0);
    stop = 1'b1; tick("ring_stop", 2'd0, MI, 4'h8, 1'b0); stop = 1'b0;

    // Dwell 3 on state 1.
    wr(4'd4, 8'd3, 2'd2, 4'h2);
    run = 1'b1; tick("d_run", 2'd0, MR, 4'h8, 1'b0); run = 1'b0;
    tick("d_s1", 2'd1, MR, 4'h1, 1'b0);
    tick("d_w3", 2'd1, MW, 4'h2, 1'b0);
    tick("d_w2", 2'd1, MW, 4'h2, 1'b0);
    tick("d_w1", 2'd1, MW, 4'h2, 1'b0);
    tick("d_s2", 2'd2, MR, 4'h2, 1'b0);
    tick("d_s3", 2'd3, MR, 4'h4, 1'b0);

    // Breakpoint on state 2, committed from WAIT.
    bkpt_en = 1'b1; bkpt_state = 2'd2;
    tick("b_s0", 2'd0, MR, 4'h8, 1'b0);
    tick("b_s1", 2'd1, MR, 4'h1, 1'b0);
    tick("b_w3", 2'd1, MW, 4'h2, 1'b0);
    tick("b_w2", 2'd1, MW, 4'h2, 1'b0);
    tick("b_w1", 2'd1, MW, 4'h2, 1'b0);
    tick("b_hit", 2'd2, MH, 4'h2, 1'b1);
    tick("b_hold", 2'd2, MH, 4'h2, 1'b0);
    step = 1'b1; tick("step", 2'd3, MH, 4'h4, 1'b0); step = 1'b0;
    tick("step_hold", 2'd3, MH, 4'h4, 1'b0);
    bkpt_en = 1'b0;

    // Halt with 2 counts left, hold, resume.
    run = 1'b1; tick("h_run", 2'd3, MR, 4'h4, 1'b0); run = 1'b0;
    tick("h_s0", 2'd0, MR, 4'h8, 1'b0);
    tick("h_s1", 2'd1, MR, 4'h1, 1'b0);
    tick("h_w3", 2'd1, MW, 4'h2, 1'b0);
    tick("h_w2", 2'd1, MW, 4'h2, 1'b0);
    halt = 1'b1; tick("h_halt", 2'd1, MH, 4'h2, 1'b0); halt = 1'b0;
    for (int k = 0; k < 4; k++) tick("h_hold", 2'd1, MH, 4'h2, 1'b0);
    run = 1'b1; tick("h_res", 2'd1, MW, 4'h2, 1'b0); run = 1'b0;
    tick("h_res1", 2'd1, MW, 4'h2, 1'b0);
    tick("h_commit", 2'd2, MR, 4'h2, 1'b0);
    tick("h_s3", 2'd3, MR, 4'h4, 1'b0);
    stop = 1'b1; tick("h_stop", 2'd0, MI, 4'h4, 1'b0); stop = 1'b0;

    // Input-dependent branch from state 0.
    wr(4'd4, 8'd0, 2'd2, 4'h2);
    wr(4'd1, 8'd0, 2'd3, 4'hA);
    in_ports = 2'd1;
    run = 1'b1; tick("br_run", 2'd0, MR, 4'h4, 1'b0); run = 1'b0;
    tick("br_in1", 2'd3, MR, 4'hA, 1'b0);
    in_ports = 2'd0; tick("br_s0", 2'd0, MR, 4'h8, 1'b0);
    in_ports = 2'd1; tick("br_in1b", 2'd3, MR, 4'hA, 1'b0);
    in_ports = 2'd0; tick("br_s0b", 2'd0, MR, 4'h8, 1'b0);
    tick("br_in0", 2'd1, MR, 4'h1, 1'b0);

    // Rewrite the entry being looked up this cycle: old data now, new next time.
    lut_we = 1'b1; lut_addr = 4'd4; lut_wdata = {8'd0, 2'd0, 4'h5};
    tick("wr_old", 2'd2, MR, 4'h2, 1'b0);
    lut_we = 1'b0;
    tick("wr_s3", 2'd3, MR, 4'h4, 1'b0);
    tick("wr_s0", 2'd0, MR, 4'h8, 1'b0);
    tick("wr_s1", 2'd1, MR, 4'h1, 1'b0);
    tick("wr_new", 2'd0, MR, 4'h5, 1'b0);

    // Reset beats run.
    rst = 1'b1; run = 1'b1; tick("rst_run", 2'd0, MI, 4'h0, 1'b0);
    rst = 1'b0; run = 1'b0;

    // Clock enable low freezes control and LUT writes.
    cke = 1'b0; run = 1'b1;
    lut_we = 1'b1; lut_addr = 4'd1; lut_wdata = {8'd0, 2'd2, 4'hF};
    tick("cke_hold", 2'd0, MI, 4'h0, 1'b0);
    cke = 1'b1; run = 1'b0; lut_we = 1'b0;

    // Re-run reproduces the programmed sequence.
    in_ports = 2'd1;
    run = 1'b1; tick("rr_run", 2'd0, MR, 4'h0, 1'b0); run = 1'b0;
    tick("rr_in1", 2'd3, MR, 4'hA, 1'b0);
    in_ports = 2'd0; tick("rr_s0", 2'd0, MR, 4'h8, 1'b0);
    tick("rr_s1", 2'd1, MR, 4'h1, 1'b0);
    tick("rr_new", 2'd0, MR, 4'h5, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iob_pfsm_dwell.md
Name: iob_pfsm_dwell

Overview:
- Programmable finite-state machine: a LUT is indexed by {current_state, input_ports_i} and returns {dwell, next_state, outputs}.
- Adds three things the basic PFSM lacks: a per-transition dwell counter (hold the current state N extra cycles before advancing), a run/halt/single-step control FSM, and a state breakpoint.
- Sits behind the PFSM CSR block; the LUT write port and control strobes are driven by software registers.

Parameters:
- STATE_W, 2, width of the PFSM state; 2^STATE_W states.
- INPUT_W, 2, width of the input_ports_i lookup field.
- OUTPUT_W, 4, width of output_ports_o.
- DWELL_W, 8, width of the per-entry dwell count.
- ENTRY_W, DWELL_W+STATE_W+OUTPUT_W, derived, LUT word width; bit fields are [OUTPUT_W-1:0] outputs, then next_state, then dwell (MSBs).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cke_i  in  1  clock enable; when low, all registers hold
- lut_we_i  in  1  LUT write strobe
- lut_addr_i  in  STATE_W+INPUT_W  LUT write address
- lut_wdata_i  in  ENTRY_W  LUT write data
- run_i  in  1  pulse: IDLE or HALT -> RUN
- halt_i  in  1  pulse: RUN or WAIT -> HALT
- step_i  in  1  pulse: in HALT, execute exactly one transition
- stop_i  in  1  pulse: any mode -> IDLE, state cleared to 0
- bkpt_en_i  in  1  breakpoint enable
- bkpt_state_i  in  STATE_W  breakpoint state
- input_ports_i  in  INPUT_W  PFSM inputs
- output_ports_o  out  OUTPUT_W  registered PFSM outputs
- state_o  out  STATE_W  current PFSM state
- mode_o  out  2  control mode: 0 IDLE, 1 RUN, 2 WAIT, 3 HALT
- bkpt_hit_o  out  1  one-cycle pulse when a breakpoint halts the machine

Behaviour:
- Reset (rst_i=1 at a clock edge, cke_i high): mode IDLE, state 0, output_ports_o 0, dwell counter 0, bkpt_hit_o 0. LUT contents are not reset.
- The LUT is a register array with asynchronous read at {state_o, input_ports_i}.
- LUT writes are honoured in every mode. A write takes effect on the next cycle's lookup; a write and a lookup to the same address in one cycle use the old data.
- IDLE: outputs and state hold. run_i -> RUN next cycle.
- RUN, each cycle, with e the current LUT entry:
  - output_ports_o <= e.outputs.
  - If e.dwell==0: state <= e.next_state.
  - Otherwise: counter <= e.dwell, pending_next <= e.next_state, mode <= WAIT. The state holds.
- WAIT:
  - The counter decrements each cycle and outputs hold.
  - When the counter reaches 1: state <= pending_next, mode <= RUN.
  - Net effect: a transition with dwell D leaves the state unchanged for D+1 cycles. Inputs are not sampled during WAIT.
- Breakpoint: if bkpt_en_i is set and the state being committed equals bkpt_state_i (from either RUN or WAIT), commit it, go to HALT, and pulse bkpt_hit_o in the same cycle mode_o becomes HALT.
- HALT:
  - Outputs and state hold.
  - run_i -> RUN. The breakpoint is not re-checked against the current state until the next commit.
  - step_i performs one RUN-cycle evaluation and returns to HALT. If that evaluation has dwell>0, the whole dwell runs in WAIT before returning to HALT.
- halt_i in RUN: HALT next cycle, with no commit that cycle. halt_i in WAIT: the counter freezes; the next run_i resumes WAIT with the remaining count.
- Priority of simultaneous requests: rst_i > stop_i > halt_i > breakpoint > step_i/run_i. run_i and step_i together in HALT: run_i wins.
- stop_i: mode IDLE, state 0, counter 0; output_ports_o keeps its last value.
- A control pulse in a mode where it has no meaning is ignored (e.g. step_i in RUN, run_i in RUN).
- cke_i low freezes everything, including LUT writes.

Test Plan:
- Reset, then program a 4-state ring (s -> s+1, outputs=1<<s, dwell 0), then run_i -> state 0,1,2,3,0 on consecutive cycles; output_ports_o 1,2,4,8 lagging state by one cycle.
- Entry for state 1 with dwell=3, then run -> state_o stays 1 for 4 cycles; mode_o shows WAIT for 3 cycles; then state 2.
- bkpt_en_i=1, bkpt_state_i=2 -> mode_o=HALT the cycle state_o becomes 2, bkpt_hit_o single pulse; step_i -> state 3, mode back to HALT, no pulse.
- halt_i mid-WAIT with 2 counts left, hold 5 cycles, then run_i -> state changes exactly 2 cycles after resume.
- Input-dependent branch (state 0, input 1 -> 3; input 0 -> 1); toggle input_ports_i -> the correct next state each time; a LUT rewrite during RUN takes effect on the following lookup only.
- rst_i asserted together with run_i during RUN -> mode IDLE, state 0, outputs 0; LUT contents are retained (re-run reproduces the sequence).
